// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared op codes, FSM states and byte-lane enables for the LSU
// Purpose: constants and types used by lsu_ctrl and lsu_load_align.
// Ports: none (package).
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic op_is_store(lsu_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - load lane select and sign/zero extension
// Purpose: pick the addressed byte/half of a memory word and extend it to 32 bits.
// Ports:
//   i_mem_dout  in  32  word read from data memory
//   i_op        in  3   latched op code
//   i_addr_lo   in  2   latched byte offset within the word
//   o_data      out 32  extended load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_mem_dout,
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_mem_dout[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_mem_dout[15:8];
      2'd2:    w_byte = i_mem_dout[23:16];
      2'd3:    w_byte = i_mem_dout[31:24];
      default: w_byte = i_mem_dout[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_mem_dout[31:16] : i_mem_dout[15:0];

    case (lsu_op_e'(i_op))
      OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {24'd0, w_byte};
      OP_LH:   o_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_mem_dout;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit controller between a CPU and a word-wide data memory
// Purpose: accept one load/store, check alignment and range, drive one memory
//   access cycle, and return an extended load result or an error response.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   CPU request handshake; req_op, req_addr, req_wdata payload
//   resp_valid/ready  response handshake; resp_rdata, resp_err payload
//   mem_addr          word address; mem_din/mem_we/mem_wbyte_enable store side
//   mem_dout          combinational read data for mem_addr
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-3:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_we,
  output logic [3:0]        mem_wbyte_enable,
  input  logic [31:0]       mem_dout
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  lsu_op_e           r_op;
  logic [1:0]        r_addr_lo;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [MEM_AW-3:0] r_mem_addr;
  logic [31:0]       r_mem_din;
  logic [3:0]        r_store_be;

  lsu_op_e           w_op;
  logic              w_accept;
  logic              w_err;
  logic [3:0]        w_store_be;
  logic [31:0]       w_store_din;
  logic [31:0]       w_load_data;
  logic              w_store_access;

  assign w_op     = lsu_op_e'(req_op);
  assign w_accept = req_valid && (r_state == ST_IDLE);

  // Alignment and range checks on the raw request
  always_comb begin
    w_err = (req_addr >> MEM_AW) != 32'd0;
    case (w_op)
      OP_LH, OP_LHU, OP_SH: if (req_addr[0])          w_err = 1'b1;
      OP_LW, OP_SW:         if (req_addr[1:0] != 2'd0) w_err = 1'b1;
      default: ;
    endcase
  end

  // Lane enables and replicated store data, computed before latching
  always_comb begin
    w_store_be  = BE_NONE;
    w_store_din = req_wdata;
    case (w_op)
      OP_SB: begin
        w_store_be  = BE_BYTE0 << req_addr[1:0];
        w_store_din = {4{req_wdata[7:0]}};
      end
      OP_SH: begin
        w_store_be  = req_addr[1] ? BE_HI_HALF : BE_LO_HALF;
        w_store_din = {2{req_wdata[15:0]}};
      end
      OP_SW:   w_store_be = BE_WORD;
      default: ;
    endcase
  end

  lsu_load_align u_load_align (
    .i_mem_dout (mem_dout),
    .i_op       (r_op),
    .i_addr_lo  (r_addr_lo),
    .o_data     (w_load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_LB;
      r_addr_lo  <= 2'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= 32'd0;
      r_store_be <= BE_NONE;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op       <= w_op;
        r_addr_lo  <= req_addr[1:0];
        r_err      <= w_err;
        r_rdata    <= 32'd0;
        r_store_be <= w_store_be;
        // mem_addr/mem_din only move for requests that will reach ACCESS
        if (!w_err) begin
          r_mem_addr <= req_addr[MEM_AW-1:2];
          if (op_is_store(w_op)) r_mem_din <= w_store_din;
        end
      end
      if (r_state == ST_ACCESS && !op_is_store(r_op)) r_rdata <= w_load_data;
    end
  end

  // Store strobes are decoded from state so an async reset drops them at once
  assign w_store_access = (r_state == ST_ACCESS) && op_is_store(r_op);

  always_comb begin
    w_state_nxt      = r_state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_we           = 1'b0;
    mem_wbyte_enable = BE_NONE;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = w_err ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_we           = w_store_access;
        mem_wbyte_enable = w_store_access ? r_store_be : BE_NONE;
        w_state_nxt      = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;

endmodule
